rollback_arbiter: RTL
=====================

# rollback_arbiter

Collects rollback and trap requests from the integer execute stage (`ix_*`) and the dcache data stage (`dd_*`). It issues at most one registered `wb_rollback_*` redirect per cycle. These are the signals that the execute stages and thread select consume to squash a thread. The block keeps one pending slot per thread, so losing requests from other threads are deferred, not lost. Younger requests from an already-redirecting thread are discarded.

## Interface
- NUM_THREADS, 4, hardware threads per core; TW = $clog2(NUM_THREADS)
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ix_instruction_valid  in  1  ix request qualifier
- ix_rollback_en  in  1  ix branch taken
- ix_rollback_pc  in  32  ix branch target
- ix_privileged_op_fault  in  1  ix privileged-op trap
- ix_pc  in  32  ix instruction PC
- ix_thread_idx  in  TW  ix thread
- ix_subcycle  in  4  ix subcycle
- dd_instruction_valid  in  1  dd request qualifier
- dd_rollback_en  in  1  dd rollback (miss/sync replay)
- dd_rollback_pc  in  32  dd replay PC
- dd_fault  in  1  dd trap
- dd_fault_cause  in  4  dd trap cause
- dd_pc  in  32  dd instruction PC
- dd_thread_idx  in  TW  dd thread
- dd_subcycle  in  4  dd subcycle
- cr_trap_handler  in  32  trap vector
- wb_rollback_en  out  1  redirect strobe
- wb_rollback_thread_idx  out  TW  redirected thread
- wb_rollback_pc  out  32  new PC
- wb_rollback_subcycle  out  4  subcycle to resume
- wb_trap  out  1  redirect is a trap
- wb_trap_cause  out  4  trap cause
- wb_trap_pc  out  32  faulting PC
- wb_rollback_pending  out  NUM_THREADS  thread has a deferred request; writeback suppresses its results
- wb_perf_rollback_ix, wb_perf_rollback_dd, wb_perf_rollback_deferred  out  1 each  perf event pulses

## Operation
- Source request: source valid && (rollback_en || fault).
  - ix fault: trap, cause 4'h6 (privileged op), target cr_trap_handler, subcycle 0.
  - dd fault: trap, cause dd_fault_cause, target cr_trap_handler, subcycle 0.
  - Fault beats rollback_en within the same source.
- Record content: {trap, cause, target_pc, fault_pc, subcycle}.
- Per-thread pending slot: valid bit plus record. wb_rollback_pending[t] = slot valid.
- Per-cycle merge, age order pending > dd > ix. For each thread, the candidate is the oldest of {pending[t], dd if thread t, ix if thread t}. Other requests for t are dropped.
- Selection: round-robin over candidate threads. The pointer starts after the last granted thread and advances only on a grant.
- Winner registered to wb_* at the next edge. Every other candidate thread is written into its pending slot (existing slot content kept).
- Squash rule: while wb_rollback_en is high for thread T, incoming ix/dd requests for T are discarded (younger, squashed). Pending[T] is already cleared by the grant.
- wb_rollback_pc = target_pc. wb_trap_pc = fault_pc; it is meaningful only when wb_trap.
- No backpressure. NUM_THREADS slots make overflow impossible.

## Timing
- Reset: all wb_* outputs 0, all slots invalid, RR pointer 0. Reset mid-operation drops all pending requests.
- Uncontested request at input cycle n: wb_rollback_en high in cycle n+1 for exactly one cycle.
- Deferred request: issued in a later cycle, at most NUM_THREADS-1 cycles after arrival.
- Same thread, ix and dd in cycle n: dd issued at n+1, ix dropped.
- Different threads, ix and dd in cycle n with no pending: RR picks one at n+1, the other issues at n+2. wb_rollback_pending for the loser is high during n+1.
- wb_rollback_en low whenever no candidate exists. Data outputs hold their last value.

## Configuration
- ROLLBACK_PERF_EN defined: wb_perf_rollback_ix/dd pulse with wb_rollback_en by the granted request's source. wb_perf_rollback_deferred pulses in each cycle a pending slot is newly written.
- ROLLBACK_PERF_EN undefined: the three perf outputs are tied 0 and the source-tracking flops are removed.

## Test plan
- ix rollback thread 1, pc 0x1000, at cycle 5 -> wb_rollback_en=1, thread 1, pc 0x1000, trap 0 at cycle 6 only.
- Same cycle ix thread 2 (pc 0x200) and dd thread 2 (pc 0x300) -> single redirect at next cycle to 0x300; 0x200 never appears.
- ix thread 0 (0x40) and dd thread 3 (0x80), RR pointer 0 -> cycle+1 thread 0/0x40 with pending[3]=1; cycle+2 thread 3/0x80, pending cleared; with ROLLBACK_PERF_EN, deferred pulses once.
- ix privileged fault, pc 0x500, thread 1, cr_trap_handler 0xFFFF0000 -> wb_trap=1, cause 6, wb_rollback_pc 0xFFFF0000, wb_trap_pc 0x500, subcycle 0.
- While wb_rollback_en for thread 2, new dd request thread 2 -> discarded; no second redirect, pending[2] stays 0.
- Reset asserted with pending[1] valid -> all outputs 0 immediately; no redirect after release.

Source files
------------

// File: rtl/rollback_arbiter.sv
// Merges ix/dd rollback and trap requests into one registered redirect per cycle.
// Optional perf event outputs are built when ROLLBACK_PERF_EN is defined.
module rollback_arbiter #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TW          = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ix_instruction_valid,
  input  logic                   ix_rollback_en,
  input  logic [31:0]            ix_rollback_pc,
  input  logic                   ix_privileged_op_fault,
  input  logic [31:0]            ix_pc,
  input  logic [TW-1:0]          ix_thread_idx,
  input  logic [3:0]             ix_subcycle,
  input  logic                   dd_instruction_valid,
  input  logic                   dd_rollback_en,
  input  logic [31:0]            dd_rollback_pc,
  input  logic                   dd_fault,
  input  logic [3:0]             dd_fault_cause,
  input  logic [31:0]            dd_pc,
  input  logic [TW-1:0]          dd_thread_idx,
  input  logic [3:0]             dd_subcycle,
  input  logic [31:0]            cr_trap_handler,
  output logic                   wb_rollback_en,
  output logic [TW-1:0]          wb_rollback_thread_idx,
  output logic [31:0]            wb_rollback_pc,
  output logic [3:0]             wb_rollback_subcycle,
  output logic                   wb_trap,
  output logic [3:0]             wb_trap_cause,
  output logic [31:0]            wb_trap_pc,
  output logic [NUM_THREADS-1:0] wb_rollback_pending,
  output logic                   wb_perf_rollback_ix,
  output logic                   wb_perf_rollback_dd,
  output logic                   wb_perf_rollback_deferred
);

  localparam logic [3:0] CAUSE_PRIV_OP = 4'h6;

  typedef struct packed {
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] target_pc;
    logic [31:0] fault_pc;
    logic [3:0]  subcycle;
  } rb_rec_t;

  rb_rec_t                 slot_rec [NUM_THREADS];
  logic [NUM_THREADS-1:0]  slot_valid;
  logic [TW-1:0]           rr_ptr;

  logic                    ix_req, dd_req;
  rb_rec_t                 ix_rec, dd_rec;
  logic [NUM_THREADS-1:0]  squash;
  logic [NUM_THREADS-1:0]  cand_valid;
  logic [NUM_THREADS-1:0]  cand_from_dd;
  rb_rec_t                 cand_rec [NUM_THREADS];
  logic                    grant_any;
  logic [TW-1:0]           grant_idx;
  logic [NUM_THREADS-1:0]  new_slot;

  // Fault wins over rollback within a source; traps resume at subcycle 0.
  always_comb begin
    ix_req           = ix_instruction_valid && (ix_rollback_en || ix_privileged_op_fault);
    dd_req           = dd_instruction_valid && (dd_rollback_en || dd_fault);
    ix_rec.trap      = ix_privileged_op_fault;
    ix_rec.cause     = ix_privileged_op_fault ? CAUSE_PRIV_OP : 4'h0;
    ix_rec.target_pc = ix_privileged_op_fault ? cr_trap_handler : ix_rollback_pc;
    ix_rec.fault_pc  = ix_pc;
    ix_rec.subcycle  = ix_privileged_op_fault ? 4'h0 : ix_subcycle;
    dd_rec.trap      = dd_fault;
    dd_rec.cause     = dd_fault ? dd_fault_cause : 4'h0;
    dd_rec.target_pc = dd_fault ? cr_trap_handler : dd_rollback_pc;
    dd_rec.fault_pc  = dd_pc;
    dd_rec.subcycle  = dd_fault ? 4'h0 : dd_subcycle;
  end

  // Per-thread oldest candidate: pending slot, then dd, then ix.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      squash[t]       = wb_rollback_en && (wb_rollback_thread_idx == TW'(t));
      cand_valid[t]   = 1'b0;
      cand_from_dd[t] = 1'b0;
      cand_rec[t]     = '0;
      if (slot_valid[t]) begin
        cand_valid[t] = 1'b1;
        cand_rec[t]   = slot_rec[t];
      end else if (dd_req && dd_thread_idx == TW'(t) && !squash[t]) begin
        cand_valid[t]   = 1'b1;
        cand_from_dd[t] = 1'b1;
        cand_rec[t]     = dd_rec;
      end else if (ix_req && ix_thread_idx == TW'(t) && !squash[t]) begin
        cand_valid[t] = 1'b1;
        cand_rec[t]   = ix_rec;
      end
    end
  end

  // Round-robin: rr_ptr names the highest-priority thread this cycle.
  always_comb begin
    int unsigned idx;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      idx = (32'(rr_ptr) + 32'(i)) % NUM_THREADS;
      if (!grant_any && cand_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = TW'(idx);
      end
    end
    for (int t = 0; t < NUM_THREADS; t++) begin
      new_slot[t] = cand_valid[t] && !slot_valid[t] && !(grant_any && grant_idx == TW'(t));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_rollback_en         <= 1'b0;
      wb_rollback_thread_idx <= '0;
      wb_rollback_pc         <= '0;
      wb_rollback_subcycle   <= '0;
      wb_trap                <= 1'b0;
      wb_trap_cause          <= '0;
      wb_trap_pc             <= '0;
      rr_ptr                 <= '0;
      slot_valid             <= '0;
      for (int t = 0; t < NUM_THREADS; t++) slot_rec[t] <= '0;
    end else begin
      wb_rollback_en <= grant_any;
      if (grant_any) begin
        wb_rollback_thread_idx <= grant_idx;
        wb_rollback_pc         <= cand_rec[grant_idx].target_pc;
        wb_rollback_subcycle   <= cand_rec[grant_idx].subcycle;
        wb_trap                <= cand_rec[grant_idx].trap;
        wb_trap_cause          <= cand_rec[grant_idx].cause;
        wb_trap_pc             <= cand_rec[grant_idx].fault_pc;
        rr_ptr                 <= TW'((32'(grant_idx) + 32'd1) % NUM_THREADS);
      end
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (grant_any && grant_idx == TW'(t)) begin
          slot_valid[t] <= 1'b0;
        end else if (new_slot[t]) begin
          slot_valid[t] <= 1'b1;
          slot_rec[t]   <= cand_rec[t];
        end
      end
    end
  end

  assign wb_rollback_pending = slot_valid;

`ifdef ROLLBACK_PERF_EN
  logic [NUM_THREADS-1:0] slot_from_dd;

  // Source of each pending record is kept so deferred grants are attributed correctly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_from_dd              <= '0;
      wb_perf_rollback_ix       <= 1'b0;
      wb_perf_rollback_dd       <= 1'b0;
      wb_perf_rollback_deferred <= 1'b0;
    end else begin
      wb_perf_rollback_ix       <= grant_any && !(slot_valid[grant_idx] ? slot_from_dd[grant_idx]
                                                                        : cand_from_dd[grant_idx]);
      wb_perf_rollback_dd       <= grant_any &&  (slot_valid[grant_idx] ? slot_from_dd[grant_idx]
                                                                        : cand_from_dd[grant_idx]);
      wb_perf_rollback_deferred <= |new_slot;
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (new_slot[t]) slot_from_dd[t] <= cand_from_dd[t];
      end
    end
  end
`else
  assign wb_perf_rollback_ix       = 1'b0;
  assign wb_perf_rollback_dd       = 1'b0;
  assign wb_perf_rollback_deferred = 1'b0;
`endif

endmodule
